msrv32_imem_resp: RTL and testbench

Instruction-side bus responder for the msrv32 core: the memory end of the fetch interface driven by the program counter block. Accepts a word-aligned instruction address and returns a 32-bit instruction after a programmable number of wait states. The ready signal it drives is the core's `ahb_ready_in`. A side write port preloads the instruction store before or between fetches.

---
 rtl/msrv32_imem_resp_pkg.sv | 32 +++
 rtl/msrv32_imem_array.sv | 30 +++
 rtl/msrv32_imem_resp.sv | 138 +++++++++++++
 tb/tb_msrv32_imem_resp.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/msrv32_imem_resp_pkg.sv
// Shared definitions for the msrv32 instruction-side responder: the NOP
// returned on errored fetches, FSM state encodings, the wait-state counter
// width and the address error check used at acceptance.
package msrv32_imem_resp_pkg;

  localparam int unsigned INSTR_W = 32;

  // RISC-V canonical NOP (addi x0, x0, 0), returned on errors and after reset.
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  // Responder FSM encodings, kept as plain constants so legacy code can share them.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'b00;
  localparam state_t ST_WAIT = 2'b01;
  localparam state_t ST_RESP = 2'b10;

  // Wait-state counter width: supports 0..7 extra data-phase cycles.
  localparam int unsigned CNT_W = 3;

  // A fetch errors when the byte address is not word aligned, or when its
  // word offset from the store base does not fit in aw index bits. The
  // subtraction is unsigned 32-bit, so addresses below the base wrap to a
  // huge offset and are flagged out of range.
  function automatic logic fetch_error(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input int unsigned aw);
    logic [31:0] word_off;
    word_off = (addr - base) >> 2;
    return (addr[1:0] != 2'b00) || ((word_off >> aw) != 32'd0);
  endfunction

endpackage

// File: rtl/msrv32_imem_array.sv
// Instruction store: 2^ADDR_WIDTH x 32 words, one synchronous write port used
// for preloading and one asynchronous read port used by the responder.
module msrv32_imem_array #(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk_in,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [31:0]           wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [31:0]           rd_data
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [31:0] mem [0:DEPTH-1];

  // Preload write at the clock edge; a read in the same cycle sees old data.
  // NOTE: the storage array has no reset - contents are defined only by
  // preloads, which keeps it mappable onto RAM macros. Non-blocking '<='
  // is used for all clocked state so every flop samples pre-edge values.
  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/msrv32_imem_resp.sv
// msrv32 instruction-side bus responder. Accepts a word-aligned fetch address
// whenever ready is high, inserts WAIT_STATES data-phase wait cycles, then
// returns the addressed instruction (or a NOP with an error flag) for one
// cycle. Back-to-back requests are accepted in the completing cycle.
module msrv32_imem_resp
  import msrv32_imem_resp_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned WAIT_STATES  = 1,
  parameter logic [31:0] BOOT_ADDRESS = 32'h0000_0000
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  fetch_req_in,
  input  logic [31:0]           i_addr_in,
  input  logic                  load_en_in,
  input  logic [ADDR_WIDTH-1:0] load_addr_in,
  input  logic [31:0]           load_data_in,
  output logic                  ahb_ready_out,
  output logic [31:0]           instr_out,
  output logic                  instr_valid_out,
  output logic                  fetch_err_out
);

  localparam bit               NO_WAIT = (WAIT_STATES == 0);
  localparam logic [CNT_W-1:0] WS_LAST = CNT_W'(WAIT_STATES);

  state_t                  state_q;
  state_t                  state_d;
  logic [CNT_W-1:0]        cnt_q;
  logic [CNT_W-1:0]        cnt_d;
  logic [ADDR_WIDTH-1:0]   idx_q;
  logic                    err_q;
  logic [31:0]             hold_q;
  logic [31:0]             rd_data;
  logic [31:0]             resp_data;
  logic [ADDR_WIDTH-1:0]   idx_now;
  logic                    err_now;
  logic                    accept;
  logic                    in_resp;

  // Address phase: a request is taken whenever the bus is ready.
  assign accept  = fetch_req_in && ahb_ready_out;
  assign in_resp = (state_q == ST_RESP);

  // Word index relative to the store base and the error verdict, both
  // evaluated on the incoming address at acceptance.
  assign idx_now = ADDR_WIDTH'((i_addr_in - BOOT_ADDRESS) >> 2);
  assign err_now = fetch_error(i_addr_in, BOOT_ADDRESS, ADDR_WIDTH);

  msrv32_imem_array #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_array (
    .clk_in  (clk_in),
    .wr_en   (load_en_in),
    .wr_addr (load_addr_in),
    .wr_data (load_data_in),
    .rd_addr (idx_q),
    .rd_data (rd_data)
  );

  // Next-state and wait counter: count 1..WAIT_STATES in WAIT, then respond.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs; a missing
    // branch would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE, ST_RESP: begin
        if (accept) begin
          if (NO_WAIT) begin
            state_d = ST_RESP;
            cnt_d   = '0;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_W'(1);
          end
        end else begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      ST_WAIT: begin
        if (cnt_q == WS_LAST) begin
          state_d = ST_RESP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM state and wait counter registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Address latch: capture word index and error verdict on acceptance.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      idx_q <= '0;
      err_q <= 1'b0;
    end else if (accept) begin
      idx_q <= idx_now;
      err_q <= err_now;
    end
  end

  // Completion data: errored fetches return the NOP and ignore the store.
  assign resp_data = err_q ? NOP_INSTR : rd_data;

  // Instruction hold: remembers the last completion so instr_out is stable
  // outside the response cycle.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      hold_q <= NOP_INSTR;
    end else if (in_resp) begin
      hold_q <= resp_data;
    end
  end

  assign ahb_ready_out   = (state_q != ST_WAIT);
  assign instr_valid_out = in_resp;
  assign fetch_err_out   = in_resp && err_q;
  assign instr_out       = in_resp ? resp_data : hold_q;

endmodule

// File: tb/tb_msrv32_imem_resp.sv
// Self-checking bench for msrv32_imem_resp. Three responders share one set of
// inputs: WAIT_STATES 0 and 1 at base 0, and WAIT_STATES 3 at base 0x1000.
// A deadline-based behavioural model predicts every output each cycle;
// directed scenarios add literal expectations on top.
module tb_msrv32_imem_resp;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int          NI  = 3;

  logic        clk;
  logic        rst_in;
  logic        fetch_req_in;
  logic [31:0] i_addr_in;
  logic        load_en_in;
  logic [9:0]  load_addr_in;
  logic [31:0] load_data_in;

  logic        ready_o [NI];
  logic        valid_o [NI];
  logic        err_o   [NI];
  logic [31:0] instr_o [NI];

  int n_checks = 0;
  int n_pass   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  msrv32_imem_resp #(.ADDR_WIDTH(10), .WAIT_STATES(0), .BOOT_ADDRESS(32'h0000_0000)) u_dut0 (
    .clk_in(clk), .rst_in(rst_in), .fetch_req_in(fetch_req_in), .i_addr_in(i_addr_in),
    .load_en_in(load_en_in), .load_addr_in(load_addr_in), .load_data_in(load_data_in),
    .ahb_ready_out(ready_o[0]), .instr_out(instr_o[0]), .instr_valid_out(valid_o[0]),
    .fetch_err_out(err_o[0]));

  msrv32_imem_resp #(.ADDR_WIDTH(10), .WAIT_STATES(1), .BOOT_ADDRESS(32'h0000_0000)) u_dut1 (
    .clk_in(clk), .rst_in(rst_in), .fetch_req_in(fetch_req_in), .i_addr_in(i_addr_in),
    .load_en_in(load_en_in), .load_addr_in(load_addr_in), .load_data_in(load_data_in),
    .ahb_ready_out(ready_o[1]), .instr_out(instr_o[1]), .instr_valid_out(valid_o[1]),
    .fetch_err_out(err_o[1]));

  msrv32_imem_resp #(.ADDR_WIDTH(10), .WAIT_STATES(3), .BOOT_ADDRESS(32'h0000_1000)) u_dut2 (
    .clk_in(clk), .rst_in(rst_in), .fetch_req_in(fetch_req_in), .i_addr_in(i_addr_in),
    .load_en_in(load_en_in), .load_addr_in(load_addr_in), .load_data_in(load_data_in),
    .ahb_ready_out(ready_o[2]), .instr_out(instr_o[2]), .instr_valid_out(valid_o[2]),
    .fetch_err_out(err_o[2]));

  // ---------------- behavioural model ----------------
  // Each responder is described by: is a fetch pending, which address, and
  // the cycle number in which it must complete (request cycle + 1 + waits).
  int          cyc = 0;
  bit          started = 1'b0;
  logic [31:0] mem_m  [0:1023];
  bit          m_pend [NI];
  int          m_done [NI];
  logic [31:0] m_addr [NI];
  logic [31:0] m_hold [NI];

  function automatic int ws_of(input int k);
    return (k == 0) ? 0 : (k == 1) ? 1 : 3;
  endfunction

  function automatic logic [31:0] base_of(input int k);
    return (k == 2) ? 32'h0000_1000 : 32'h0000_0000;
  endfunction

  function automatic bit exp_valid(input int k);
    return m_pend[k] && (cyc == m_done[k]);
  endfunction

  function automatic bit exp_ready(input int k);
    return !(m_pend[k] && (cyc < m_done[k]));
  endfunction

  function automatic bit addr_bad(input int k);
    logic [31:0] off;
    off = m_addr[k] - base_of(k);
    return (m_addr[k] % 4 != 0) || (off / 4 >= 1024);
  endfunction

  function automatic logic [31:0] exp_instr(input int k);
    logic [31:0] off;
    if (!exp_valid(k)) return m_hold[k];
    if (addr_bad(k)) return NOP;
    off = (m_addr[k] - base_of(k)) / 4;
    return mem_m[off[9:0]];
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (load_en_in) mem_m[load_addr_in] <= load_data_in;
    if (rst_in) begin
      started <= 1'b1;
      for (int k = 0; k < NI; k++) begin
        m_pend[k] <= 1'b0;
        m_hold[k] <= NOP;
      end
    end else begin
      for (int k = 0; k < NI; k++) begin
        if (exp_valid(k)) m_hold[k] <= exp_instr(k);
        if (fetch_req_in && exp_ready(k)) begin
          m_pend[k] <= 1'b1;
          m_addr[k] <= i_addr_in;
          m_done[k] <= cyc + 1 + ws_of(k);
        end else if (exp_valid(k)) begin
          m_pend[k] <= 1'b0;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cycle %0d: got %h, expected %h", name, cyc, act, exp);
  endtask

  // Compare process: every DUT output against the model, every cycle.
  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < NI; k++) begin
        check($sformatf("ready[%0d]", k), 32'(ready_o[k]), 32'(exp_ready(k)));
        check($sformatf("valid[%0d]", k), 32'(valid_o[k]), 32'(exp_valid(k)));
        check($sformatf("err[%0d]", k),   32'(err_o[k]),   32'(exp_valid(k) && addr_bad(k)));
        check($sformatf("instr[%0d]", k), instr_o[k],      exp_instr(k));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic preload(input int idx, input logic [31:0] data);
    load_en_in   = 1'b1;
    load_addr_in = 10'(idx);
    load_data_in = data;
    tick();
    load_en_in = 1'b0;
  endtask

  task automatic fetch_once(input logic [31:0] a);
    fetch_req_in = 1'b1;
    i_addr_in    = a;
    tick();
    fetch_req_in = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      0, 1, 2, 3, 4, 5: return 32'($urandom_range(0, 1023)) << 2;
      6:       return 32'h0000_1000 + (32'($urandom_range(0, 1023)) << 2);
      7:       return (32'($urandom_range(0, 1023)) << 2) | 32'($urandom_range(1, 3));
      8:       return 32'hFFFF_FFFC;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst_in       = 1'b1;
    fetch_req_in = 1'b0;
    i_addr_in    = '0;
    load_en_in   = 1'b0;
    load_addr_in = '0;
    load_data_in = '0;
    tick(2);
    rst_in = 1'b0;

    // Reset values.
    check("rst_ready", 32'(ready_o[0]), 32'd1);
    check("rst_valid", 32'(valid_o[0]), 32'd0);
    check("rst_err",   32'(err_o[0]),   32'd0);
    check("rst_instr", instr_o[2],      32'h0000_0013);

    // Fill the store, then place the directed words.
    for (int i = 0; i < 1024; i++) preload(i, $urandom);
    preload(0, 32'h0050_0093);
    preload(1, 32'hBBBB_0002);
    preload(2, 32'h1111_1111);
    preload(3, 32'h3333_0003);
    tick(2);

    // One wait state: ready low one cycle, then the instruction.
    fetch_once(32'h0);
    check("ws1_ready_low", 32'(ready_o[1]), 32'd0);
    check("ws0_valid",     32'(valid_o[0]), 32'd1);
    check("ws0_instr",     instr_o[0],      32'h0050_0093);
    tick();
    check("ws1_valid",     32'(valid_o[1]), 32'd1);
    check("ws1_instr",     instr_o[1],      32'h0050_0093);
    tick(6);

    // Zero wait states, back-to-back: one completion per cycle.
    fetch_req_in = 1'b1;
    i_addr_in    = 32'h0;
    tick();
    check("b2b_a_valid", 32'(valid_o[0]), 32'd1);
    check("b2b_a_ready", 32'(ready_o[0]), 32'd1);
    check("b2b_a_instr", instr_o[0],      32'h0050_0093);
    i_addr_in = 32'h4;
    tick();
    check("b2b_b_valid", 32'(valid_o[0]), 32'd1);
    check("b2b_b_ready", 32'(ready_o[0]), 32'd1);
    check("b2b_b_instr", instr_o[0],      32'hBBBB_0002);
    i_addr_in = 32'h8;
    tick();
    check("b2b_c_valid", 32'(valid_o[0]), 32'd1);
    check("b2b_c_ready", 32'(ready_o[0]), 32'd1);
    check("b2b_c_instr", instr_o[0],      32'h1111_1111);
    fetch_req_in = 1'b0;
    tick(6);

    // Misaligned and out-of-range fetches complete with an error NOP.
    fetch_once(32'h6);
    check("mis_err",   32'(err_o[0]), 32'd1);
    check("mis_instr", instr_o[0],    32'h0000_0013);
    tick(6);
    fetch_once(32'h1000);
    check("oor_err",   32'(err_o[0]), 32'd1);
    check("oor_instr", instr_o[0],    32'h0000_0013);
    tick(6);

    // Preload in the response cycle returns old data; the next fetch sees new.
    fetch_once(32'h8);
    load_en_in   = 1'b1;
    load_addr_in = 10'd2;
    load_data_in = 32'hDEAD_BEEF;
    check("wr_same_old", instr_o[0], 32'h1111_1111);
    tick();
    load_en_in = 1'b0;
    tick(2);
    fetch_once(32'h8);
    check("wr_same_new", instr_o[0], 32'hDEAD_BEEF);
    tick(6);

    // Reset in the second wait cycle drops the fetch; preload still lands.
    fetch_once(32'h1008);
    tick();
    rst_in       = 1'b1;
    load_en_in   = 1'b1;
    load_addr_in = 10'd5;
    load_data_in = 32'h5555_AAAA;
    tick();
    check("rst_mid_ready", 32'(ready_o[2]), 32'd1);
    check("rst_mid_valid", 32'(valid_o[2]), 32'd0);
    rst_in     = 1'b0;
    load_en_in = 1'b0;
    fetch_once(32'h1004);
    check("post_rst_busy", 32'(ready_o[2]), 32'd0);
    tick(3);
    check("post_rst_valid", 32'(valid_o[2]), 32'd1);
    check("post_rst_instr", instr_o[2],      32'hBBBB_0002);
    tick(6);
    fetch_once(32'h14);
    check("rst_preload", instr_o[0], 32'h5555_AAAA);
    tick(6);

    // Requests while ready is low are ignored; the latched address wins.
    fetch_req_in = 1'b1;
    i_addr_in    = 32'h100C;
    tick();
    i_addr_in = 32'h1000;
    tick();
    fetch_req_in = 1'b0;
    i_addr_in    = 32'h1004;
    tick();
    fetch_req_in = 1'b1;
    i_addr_in    = 32'h1008;
    tick();
    check("ignore_valid", 32'(valid_o[2]), 32'd1);
    check("ignore_instr", instr_o[2],      32'h3333_0003);
    fetch_req_in = 1'b0;
    tick(6);

    // Randomized traffic with preloads and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      rst_in       = ($urandom_range(0, 99) == 0);
      fetch_req_in = ($urandom_range(0, 2) != 0);
      i_addr_in    = rand_addr();
      load_en_in   = ($urandom_range(0, 4) == 0);
      load_addr_in = 10'($urandom_range(0, 1023));
      load_data_in = $urandom;
      tick();
    end
    rst_in       = 1'b0;
    fetch_req_in = 1'b0;
    load_en_in   = 1'b0;
    tick(6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
